// File: rtl/onehot_req_arbiter.sv
// onehot_req_arbiter: captures request pulses into sticky pending bits and
// hands them out one at a time as a strictly one-hot grant with round-robin
// priority, behind a valid/ready handshake. The grant drives the d input of
// the 4-to-2 encoder, whose output is only meaningful for one-hot inputs.
//
// Optional build macro: ARB_OVERRUN_DET_EN
//   defined   -> sticky per-line overrun flags (request merged into an
//                already-pending bit), cleared by ovr_clr
//   undefined -> overrun tied to zero, ovr_clr ignored
//
// IDX_W must equal clog2(N_REQ); N_REQ legal range is 2..16.
module onehot_req_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             ready,
    output logic [N_REQ-1:0] grant,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overrun,
    input  logic             ovr_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q,   state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [IDX_W-1:0] last_q,    last_d;

    // Bits retired this cycle (zero unless a grant is handed over).
    logic [N_REQ-1:0] accepted;
    // Pending lines other than the one currently granted.
    logic [N_REQ-1:0] remaining;

    // Round-robin search: first set bit of v scanning last+1, last+2, ...
    // modulo N_REQ. Scanning all N_REQ positions ends at last itself, so a
    // lone request on the most recently served line is still found.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] v,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] pos;
        logic             found;
        int               j;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(last) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            pos = IDX_W'(j);
            if (!found && v[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Binary index to one-hot line vector.
    function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    // Next-state logic: FSM transitions, grant selection, pending update.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        accepted  = '0;
        remaining = '0;

        case (state_q)
            IDLE: begin
                // ready is deliberately not looked at here: nothing is offered.
                if (pending_q != '0) begin
                    idx_d   = rr_pick(pending_q, last_q);
                    grant_d = to_onehot(rr_pick(pending_q, last_q));
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // While stalled the offer is frozen, even if a higher-priority
                // line arrives; the downstream sees a stable grant/idx.
                if (ready) begin
                    accepted  = grant_q;
                    last_d    = idx_q;
                    remaining = pending_q & ~grant_q;
                    if (remaining != '0) begin
                        // Back-to-back: priority already rotated past idx_q.
                        idx_d   = rr_pick(remaining, idx_q);
                        grant_d = to_onehot(rr_pick(remaining, idx_q));
                    end else begin
                        idx_d   = '0;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        // A new request on a line being accepted this cycle re-arms it.
        pending_d = (pending_q & ~accepted) | req;
    end

    // State, pending and offered-grant registers; reset discards all work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
        end
    end

    assign grant   = grant_q;
    assign valid   = (state_q == GRANT);
    assign idx     = idx_q;
    assign pending = pending_q;

`ifdef ARB_OVERRUN_DET_EN
    logic [N_REQ-1:0] overrun_q, overrun_d;
    logic [N_REQ-1:0] ovr_set;

    // Overrun: a request landing on a line that is already pending and is
    // not being retired this cycle is merged, i.e. one request is lost.
    // A fresh set condition beats a simultaneous clear.
    always_comb begin
        ovr_set = req & pending_q & ~accepted;
        if (ovr_clr) begin
            overrun_d = ovr_set;
        end else begin
            overrun_d = overrun_q | ovr_set;
        end
    end

    // Sticky overrun flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    logic ovr_clr_unused;

    assign ovr_clr_unused = ovr_clr;
    assign overrun        = '0;
`endif

    // The encoder downstream is only correct for one-hot inputs.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_q));
    a_valid_iff_grant: assert property (@(posedge clk) disable iff (rst)
        valid == (grant_q != '0));
    a_idx_matches: assert property (@(posedge clk) disable iff (rst)
        valid |-> (grant_q == to_onehot(idx_q)));

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Directed bench for onehot_req_arbiter (N_REQ=4). Inputs change and outputs
// are observed on the falling clock edge, away from the active rising edge.
module tb_onehot_req_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] idx;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       ovr_clr;

    int checks = 0;
    int errors = 0;

`ifdef ARB_OVERRUN_DET_EN
    localparam logic [3:0] OVR_EXP = 4'b0010;
`else
    localparam logic [3:0] OVR_EXP = 4'b0000;
`endif

    onehot_req_arbiter #(.N_REQ(4), .IDX_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ready   (ready),
        .grant   (grant),
        .valid   (valid),
        .idx     (idx),
        .pending (pending),
        .overrun (overrun),
        .ovr_clr (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; ready = 1'b0; ovr_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; ready = 1'b0; ovr_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun: got %b expected 0000", overrun); end
        rst = 1'b0;
    endtask

    task automatic test_single_pulse();
        do_reset();
        @(negedge clk);
        req = 4'b0100; ready = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL pulse_pending: got %b expected 0100", pending); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pulse_valid_early: got %b expected 0", valid); end
        @(negedge clk);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pulse_valid: got %b expected 1", valid); end
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL pulse_grant: got %b expected 0100", grant); end
        checks++; if (idx !== 2'd2) begin errors++; $display("FAIL pulse_idx: got %0d expected 2", idx); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pulse_valid_drop: got %b expected 0", valid); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL pulse_grant_drop: got %b expected 0000", grant); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL pulse_pending_clr: got %b expected 0000", pending); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [1:0] exp_i [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        @(negedge clk);
        req = 4'b1111; ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (grant !== exp_g[i] || valid !== 1'b1) begin errors++; $display("FAIL rr_grant[%0d]: got %b valid %b expected %b valid 1", i, grant, valid, exp_g[i]); end
            checks++; if (idx !== exp_i[i]) begin errors++; $display("FAIL rr_idx[%0d]: got %0d expected %0d", i, idx, exp_i[i]); end
        end
        req = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        req = 4'b0001; ready = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = (i == 0) ? 4'b1000 : 4'b0000;
            checks++; if (grant !== 4'b0001 || valid !== 1'b1) begin errors++; $display("FAIL stall_grant[%0d]: got %b valid %b expected 0001 valid 1", i, grant, valid); end
        end
        ready = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL stall_next_grant: got %b expected 1000", grant); end
        checks++; if (idx !== 2'd3) begin errors++; $display("FAIL stall_next_idx: got %0d expected 3", idx); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_drain_valid: got %b expected 0", valid); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL stall_drain_pending: got %b expected 0000", pending); end
    endtask

    task automatic test_set_wins();
        do_reset();
        @(negedge clk);
        req = 4'b0100; ready = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL setwin_grant1: got %b expected 0100", grant); end
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL setwin_pending: got %b expected 0100", pending); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL setwin_idle: got %b expected 0", valid); end
        @(negedge clk);
        checks++; if (grant !== 4'b0100 || idx !== 2'd2) begin errors++; $display("FAIL setwin_regrant: got %b idx %0d expected 0100 idx 2", grant, idx); end
        @(negedge clk);
        checks++; if (pending !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL setwin_drain: got %b valid %b expected 0000 valid 0", pending, valid); end
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        @(negedge clk);
        req = 4'b1011; ready = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        checks++; if (valid !== 1'b1 || pending !== 4'b1011) begin errors++; $display("FAIL midrst_pre: got valid %b pending %b expected valid 1 pending 1011", valid, pending); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", valid); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midrst_grant: got %b expected 0000", grant); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL midrst_pending: got %b expected 0000", pending); end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010; ready = 1'b1;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 4'b0010 || idx !== 2'd1) begin errors++; $display("FAIL midrst_after: got %b idx %0d expected 0010 idx 1", grant, idx); end
    endtask

    task automatic test_overrun();
        do_reset();
        @(negedge clk);
        req = 4'b0010; ready = 1'b0;
        @(negedge clk);
        req = 4'b0000;
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_first: got %b expected 0000", overrun); end
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        checks++; if (overrun !== OVR_EXP) begin errors++; $display("FAIL ovr_set: got %b expected %b", overrun, OVR_EXP); end
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clr: got %b expected 0000", overrun); end
        ovr_clr = 1'b1; req = 4'b0010;
        @(negedge clk);
        ovr_clr = 1'b0; req = 4'b0000;
        checks++; if (overrun !== OVR_EXP) begin errors++; $display("FAIL ovr_set_beats_clr: got %b expected %b", overrun, OVR_EXP); end
        ready = 1'b1;
        @(negedge clk);
        checks++; if (overrun !== OVR_EXP) begin errors++; $display("FAIL ovr_sticky: got %b expected %b", overrun, OVR_EXP); end
    endtask

    initial begin
        rst = 1'b1; req = '0; ready = 1'b0; ovr_clr = 1'b0;
        test_reset();
        test_single_pulse();
        test_round_robin();
        test_stall();
        test_set_wins();
        test_reset_mid_handshake();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
